// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command codes, frame sizes, FSM states.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CMD_BITS   = 2;
  localparam int unsigned CNT_W      = 4;

  localparam logic [CMD_BITS-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_BITS-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_BITS-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_BITS-1:0] CMD_RD_DATA = 2'b11;

  // One request as it goes out on MOSI, MSB first.
  typedef struct packed {
    logic [CMD_BITS-1:0]  cmd;
    logic [DATA_BITS-1:0] data;
  } frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ROUTE,
    ST_SHIFT,
    ST_WAIT,
    ST_CAPTURE,
    ST_END
  } state_e;

endpackage

// File: rtl/spi_master_shift.sv
// Datapath for the SPI master: parallel-load MOSI shifter and MISO capture shifter.
module spi_master_shift
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  frame_t               load_val,
  input  logic                 shift_en,
  input  logic                 cap_en,
  input  logic                 miso,
  output logic                 tx_msb,
  output logic [DATA_BITS-1:0] rx_byte
);

  logic [FRAME_BITS-1:0] tx_q;

  assign tx_msb = tx_q[FRAME_BITS-1];

  // Transmit shifter: load a whole frame, then move it out MSB first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (load) begin
      tx_q <= load_val;
    end else if (shift_en) begin
      tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Receive shifter: MISO enters at the LSB, so the first bit ends up as the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_byte <= '0;
    end else if (cap_en) begin
      rx_byte <= {rx_byte[DATA_BITS-2:0], miso};
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: serialises 2-bit command + 8-bit payload frames on the shared clk,
// and returns the MISO reply byte for read-data commands.
// Optional build macro SPI_MASTER_AUTO_RD_EN: a read-addr request is followed
// automatically by a read-data frame before returning to idle.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 3,
  parameter int unsigned END_GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CMD_BITS-1:0]  cmd,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic                ss_n_d, mosi_d, rd_valid_d;
  logic                load, shift_en, cap_en, tx_msb;
  frame_t              load_val;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  spi_master_shift u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .shift_en (shift_en),
    .cap_en   (cap_en),
    .miso     (MISO),
    .tx_msb   (tx_msb),
    .rx_byte  (rd_data)
  );

  // Next state and next output values; outputs describe the state being entered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    ss_n_d        = 1'b1;
    mosi_d        = 1'b0;
    rd_valid_d    = 1'b0;
    load          = 1'b0;
    shift_en      = 1'b0;
    cap_en        = 1'b0;
    load_val.cmd  = cmd;
    load_val.data = cmd_data;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_START;
          cmd_d   = cmd;
          load    = 1'b1;
          ss_n_d  = 1'b0;
        end
      end
      ST_START: begin
        state_d = ST_ROUTE;
        ss_n_d  = 1'b0;
        mosi_d  = cmd_q[1];
      end
      ST_ROUTE: begin
        state_d  = ST_SHIFT;
        cnt_d    = CNT_W'(FRAME_BITS - 1);
        ss_n_d   = 1'b0;
        mosi_d   = tx_msb;
        shift_en = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_W'(1);
          ss_n_d   = 1'b0;
          mosi_d   = tx_msb;
          shift_en = 1'b1;
        end else if (cmd_q == CMD_RD_DATA) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_WAIT - 1);
          ss_n_d  = 1'b0;
        end else begin
          state_d = ST_END;
          cnt_d   = CNT_W'(END_GAP - 1);
        end
      end
      ST_WAIT: begin
        ss_n_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_CAPTURE;
          cnt_d   = CNT_W'(DATA_BITS - 1);
        end
      end
      ST_CAPTURE: begin
        cap_en = 1'b1;
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CNT_W'(1);
          ss_n_d = 1'b0;
        end else begin
          state_d    = ST_END;
          cnt_d      = CNT_W'(END_GAP - 1);
          rd_valid_d = 1'b1;
        end
      end
      ST_END: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef SPI_MASTER_AUTO_RD_EN
          if (cmd_q == CMD_RD_ADDR) begin
            state_d       = ST_START;
            cmd_d         = CMD_RD_DATA;
            load          = 1'b1;
            load_val.cmd  = CMD_RD_DATA;
            load_val.data = '0;
            ss_n_d        = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      SS_n     <= ss_n_d;
      MOSI     <= mosi_d;
      rd_valid <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: per-cycle expected waveform built from frame rules.
module tb_spi_master;

  localparam int unsigned RD_WAIT = 3;
  localparam int unsigned END_GAP = 2;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, SS_n, MOSI, MISO;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       ss_n;
    logic       mosi;
    logic       rdy;
    logic       rv;
    logic       chk_rd;
    logic       drive;
    logic       miso;
    logic [7:0] rdd;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_rx;

  spi_master #(.RD_WAIT(RD_WAIT), .END_GAP(END_GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_data  (cmd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic ss, input logic mo, input logic rdy);
    exp_t e;
    e = '0;
    e.ss_n = ss;
    e.mosi = mo;
    e.rdy  = rdy;
    return e;
  endfunction

  // One frame: START, ROUTE, 10 data bits, optional wait+capture, then the end gap.
  task automatic add_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] rx);
    logic [11:0] tx;
    exp_t e;
    tx = {1'b0, c[1], c, d};
    for (int i = 0; i < 12; i++) q.push_back(mk(1'b0, tx[11-i], 1'b0));
    if (c == 2'b11) begin
      for (int i = 0; i < int'(RD_WAIT); i++) q.push_back(mk(1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 8; i++) begin
        e = mk(1'b0, 1'b0, 1'b0);
        e.drive = 1'b1;
        e.miso  = rx[7-i];
        q.push_back(e);
      end
      last_rx = rx;
    end
    for (int i = 0; i < int'(END_GAP); i++) begin
      e = mk(1'b1, 1'b0, 1'b0);
      if (i == 0 && c == 2'b11) begin
        e.rv     = 1'b1;
        e.chk_rd = 1'b1;
        e.rdd    = rx;
      end
      q.push_back(e);
    end
  endtask

  // Issue one request and compare every cycle until the block is idle again.
  // spam: hold a 01/FF request on the inputs throughout; abort_at: cycle index to pulse reset.
  task automatic run_req(input logic [1:0] c, input logic [7:0] d, input logic [7:0] rx,
                         input bit spam, input int abort_at);
    exp_t e;
    q.delete();
    add_frame(c, d, rx);
`ifdef SPI_MASTER_AUTO_RD_EN
    if (c == 2'b10) add_frame(2'b11, 8'h00, rx);
`endif
    e = mk(1'b1, 1'b0, 1'b1);
    e.chk_rd = 1'b1;
    e.rdd    = last_rx;
    q.push_back(e);

    cmd_valid = 1'b1;
    cmd       = c;
    cmd_data  = d;
    @(posedge clk); #1;
    for (int idx = 0; idx < q.size(); idx++) begin
      e = q[idx];
      if (spam) begin
        cmd_valid = 1'b1;
        cmd       = 2'b01;
        cmd_data  = 8'hFF;
      end else begin
        cmd_valid = (idx < q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd       = 2'($urandom);
        cmd_data  = 8'($urandom);
      end
      MISO = e.drive ? e.miso : 1'($urandom_range(0, 1));
      chk($sformatf("ss_n[c%0d i%0d]", c, idx), {7'b0, SS_n}, {7'b0, e.ss_n});
      chk($sformatf("mosi[c%0d i%0d]", c, idx), {7'b0, MOSI}, {7'b0, e.mosi});
      chk($sformatf("cmd_ready[c%0d i%0d]", c, idx), {7'b0, cmd_ready}, {7'b0, e.rdy});
      chk($sformatf("busy[c%0d i%0d]", c, idx), {7'b0, busy}, {7'b0, !e.rdy});
      chk($sformatf("rd_valid[c%0d i%0d]", c, idx), {7'b0, rd_valid}, {7'b0, e.rv});
      if (e.chk_rd) chk($sformatf("rd_data[c%0d i%0d]", c, idx), rd_data, e.rdd);
      if (idx == abort_at) begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        last_rx = 8'h00;
        chk("abort_ss_n", {7'b0, SS_n}, 8'h01);
        chk("abort_mosi", {7'b0, MOSI}, 8'h00);
        chk("abort_ready", {7'b0, cmd_ready}, 8'h01);
        chk("abort_rd_data", rd_data, 8'h00);
        for (int k = 0; k < 30; k++) begin
          MISO = 1'($urandom_range(0, 1));
          chk($sformatf("abort_rd_valid[%0d]", k), {7'b0, rd_valid}, 8'h00);
          chk($sformatf("abort_idle_ss_n[%0d]", k), {7'b0, SS_n}, 8'h01);
          @(posedge clk); #1;
        end
        return;
      end
      if (idx < q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [1:0] rc;
    logic [7:0] rd, rr;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    cmd_data  = 8'h00;
    MISO      = 1'b0;
    last_rx   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_ss_n", {7'b0, SS_n}, 8'h01);
    chk("rst_mosi", {7'b0, MOSI}, 8'h00);
    chk("rst_ready", {7'b0, cmd_ready}, 8'h01);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_rd_valid", {7'b0, rd_valid}, 8'h00);
    chk("rst_rd_data", rd_data, 8'h00);
    @(posedge clk); #1;

    // Directed write frame and read-data frame.
    run_req(2'b00, 8'hA5, 8'h00, 1'b0, -1);
    run_req(2'b11, 8'($urandom), 8'h3C, 1'b0, -1);

    // Requests held high while busy are ignored, then taken at idle.
    run_req(2'b11, 8'h5A, 8'($urandom), 1'b1, -1);
    run_req(2'b01, 8'hFF, 8'h00, 1'b0, -1);

    // Reset during SHIFT bit 5 of a read-data frame, then a clean write.
    run_req(2'b11, 8'($urandom), 8'($urandom), 1'b0, 7);
    run_req(2'b00, 8'($urandom), 8'h00, 1'b0, -1);

    // Read-addr: single frame, or frame pair when auto-read is built in.
    run_req(2'b10, 8'h12, 8'h7E, 1'b0, -1);

    // Random requests.
    for (int n = 0; n < 10; n++) begin
      rc = 2'($urandom);
      rd = 8'($urandom);
      rr = 8'($urandom);
      run_req(rc, rd, rr, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
